// File: rtl/execute_muldiv_pkg.sv
// Shared op codes, FSM states and operand-signedness helpers for the RV-M multiply/divide unit.
package execute_muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } muldiv_state_e;

    // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OpMulh) || (f == OpMulhsu) || (f == OpDiv) || (f == OpRem);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OpMulh) || (f == OpDiv) || (f == OpRem);
    endfunction

endpackage

// File: rtl/execute_muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one XLEN+1-bit adder-subtractor.
// Works on operand magnitudes; signs are reapplied on the registered result.
module execute_muldiv_datapath
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            special_o,
    output logic [XLEN-1:0] res_o
);

    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            a_neg_q, a_neg_d, b_neg_q, b_neg_d, spec_q, spec_d;

    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_val;

    logic            is_mul, quo_bit;
    logic [XLEN:0]   add_x, add_y, sum;

    logic [2*XLEN-1:0] prod_raw, prod;
    logic [XLEN-1:0]   quo, rem;

    // Operand magnitudes and one-cycle special cases, decoded from the request inputs.
    always_comb begin
        a_neg     = op_a_signed(func3_i) & op_a_i[XLEN-1];
        b_neg     = op_b_signed(func3_i) & op_b_i[XLEN-1];
        a_mag     = a_neg ? -op_a_i : op_a_i;
        b_mag     = b_neg ? -op_b_i : op_b_i;
        div_zero  = func3_i[2] && (op_b_i == '0);
        div_ovf   = ((func3_i == OpDiv) || (func3_i == OpRem)) &&
                    (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        special_o = div_zero || div_ovf;
        // func3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) spec_val = func3_i[1] ? op_a_i : '1;
        else          spec_val = func3_i[1] ? '0 : op_a_i;
    end

    // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide.
    always_comb begin
        is_mul  = ~op_q[2];
        add_x   = is_mul ? {1'b0, acc_q} : {acc_q, lo_q[XLEN-1]};
        add_y   = (is_mul && !lo_q[0]) ? '0 : {1'b0, b_q};
        sum     = is_mul ? (add_x + add_y) : (add_x - add_y);
        quo_bit = ~sum[XLEN];
    end

    // Next-state for the accumulator / shift registers.
    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        spec_d  = spec_q;
        if (load_i) begin
            op_d    = func3_i;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            spec_d  = special_o;
            acc_d   = '0;
            if (special_o) begin
                lo_d = spec_val;
            end else if (!func3_i[2]) begin
                lo_d = b_mag;  // multiplier bits consumed from the bottom
                b_d  = a_mag;
            end else begin
                lo_d = a_mag;  // dividend bits consumed from the top, quotient fills bottom
                b_d  = b_mag;
            end
        end else if (step_i) begin
            if (is_mul) begin
                acc_d = sum[XLEN:1];
                lo_d  = {sum[0], lo_q[XLEN-1:1]};
            end else begin
                acc_d = quo_bit ? sum[XLEN-1:0] : add_x[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], quo_bit};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            spec_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            spec_q  <= spec_d;
        end
    end

    // Sign fix-up and result select from registered state only.
    always_comb begin
        prod_raw = {acc_q, lo_q};
        prod     = (a_neg_q ^ b_neg_q) ? -prod_raw : prod_raw;
        quo      = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem      = a_neg_q ? -acc_q : acc_q;
        res_o    = '0;
        if (spec_q) begin
            res_o = lo_q;
        end else begin
            case (op_q)
                OpMul:                    res_o = prod[XLEN-1:0];
                OpMulh, OpMulhsu, OpMulhu: res_o = prod[2*XLEN-1:XLEN];
                OpDiv, OpDivu:            res_o = quo;
                default:                  res_o = rem;
            endcase
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV-M multiply/divide execute unit: control FSM, iteration counter and result registers.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REGNUM_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                start,
    input  logic [2:0]          func3,
    input  logic [XLEN-1:0]     opA,
    input  logic [XLEN-1:0]     opB,
    input  logic [REGNUM_W-1:0] rdIn,
    output logic                busy,
    output logic                done,
    output logic [XLEN-1:0]     result,
    output logic [REGNUM_W-1:0] rdOut
);

    localparam int unsigned CntW = $clog2(XLEN + 1);

    muldiv_state_e       state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [REGNUM_W-1:0] tag_q, tag_d, rd_q, rd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;
    logic                load, step, special;
    logic [XLEN-1:0]     dp_res;

    execute_muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .func3_i  (func3),
        .op_a_i   (opA),
        .op_b_i   (opB),
        .special_o(special),
        .res_o    (dp_res)
    );

    // Next-state, iteration control and busy; flush wins over start and over completion.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tag_d    = tag_q;
        result_d = result_q;
        rd_d     = rd_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    load  = 1'b1;
                    busy  = 1'b1;
                    tag_d = rdIn;
                    if (special) begin
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                        count_d = CntW'(XLEN);
                    end
                end
            end
            StBusy: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = StIdle;
                    count_d = '0;
                end else begin
                    step    = 1'b1;
                    count_d = count_q - CntW'(1);
                    if (count_d == '0) state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                state_d = StIdle;
                if (!flush) begin
                    done_d   = 1'b1;
                    result_d = dp_res;
                    rd_d     = tag_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            tag_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign rdOut  = rd_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv (XLEN=32) against an arithmetic reference model.
module tb_execute_muldiv;

    localparam int XLEN     = 32;
    localparam int REGNUM_W = 5;
    localparam int NORM_LAT = XLEN + 1;

    logic                clk = 1'b0;
    logic                reset, flush, start;
    logic [2:0]          func3;
    logic [XLEN-1:0]     opA, opB;
    logic [REGNUM_W-1:0] rdIn;
    logic                busy, done;
    logic [XLEN-1:0]     result;
    logic [REGNUM_W-1:0] rdOut;

    int errors = 0;
    int checks = 0;

    execute_muldiv #(
        .XLEN    (XLEN),
        .REGNUM_W(REGNUM_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .start (start),
        .func3 (func3),
        .opA   (opA),
        .opB   (opB),
        .rdIn  (rdIn),
        .busy  (busy),
        .done  (done),
        .result(result),
        .rdOut (rdOut)
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic following the RV-M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        p;
        logic signed [63:0] sa, sb;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    // Issue one op, scramble the operand inputs after acceptance, wait (bounded) for done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat);
        @(negedge clk);
        func3 = f; opA = a; opB = b; rdIn = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; opA = $urandom; opB = $urandom; rdIn = 5'($urandom); func3 = 3'($urandom);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = result;
        rdo = rdOut;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        func3 = '0; opA = '0; opB = '0; rdIn = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (rdOut !== 5'h0) begin errors++; $display("FAIL reset_rdout: got %h want 0", rdOut); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  vf [8] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] va [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ve [8] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          vl [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(vf[i], va[i], vb[i], 5'(i + 1), res, rdo, lat);
            checks++;
            if (res !== ve[i]) begin
                errors++; $display("FAIL dir%0d_result: got %h want %h", i, res, ve[i]);
            end
            checks++;
            if (lat != vl[i]) begin
                errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, vl[i]);
            end
            checks++;
            if (rdo !== 5'(i + 1)) begin
                errors++; $display("FAIL dir%0d_rdout: got %0d want %0d", i, rdo, i + 1);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h0 || rdOut !== 5'd8) begin
            errors++; $display("FAIL hold_result: got %h/%0d want 0/8", result, rdOut);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        logic [4:0]  prev_rd, rdo;
        int          lat, seen;
        run_op(3'd0, 32'd11, 32'd13, 5'd9, prev, prev_rd, lat);
        // Flush in BUSY at cycle 10.
        @(negedge clk);
        func3 = 3'd0; opA = 32'd3; opB = 32'd5; rdIn = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d dones want 0", seen); end
        checks++;
        if (result !== prev || rdOut !== prev_rd) begin
            errors++; $display("FAIL flush_hold: got %h/%0d want %h/%0d", result, rdOut, prev, prev_rd);
        end
        // Flush while in DONE (one-cycle special op).
        @(negedge clk);
        func3 = 3'd5; opA = 32'd5; opB = 32'd0; rdIn = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== prev) begin
            errors++; $display("FAIL flush_done_state: got done=%b busy=%b res=%h want 0 0 %h",
                               done, busy, result, prev);
        end
        // Start and flush together in IDLE: start ignored.
        @(negedge clk);
        func3 = 3'd5; opA = 32'd5; opB = 32'd0; start = 1'b1; flush = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_start_ignored: got %0d want 0", seen); end
        run_op(3'd0, 32'd6, 32'd7, 5'd4, res, rdo, lat);
        checks++;
        if (res !== 32'd42 || lat != NORM_LAT) begin
            errors++; $display("FAIL after_flush_op: got %h lat %0d want 2a lat %0d", res, lat, NORM_LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        @(negedge clk);
        func3 = 3'd5; opA = 32'd1000; opB = 32'd3; rdIn = 5'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rdOut !== 5'h0) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b res=%h rd=%0d want all 0",
                               busy, done, result, rdOut);
        end
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd5, 32'd1000, 32'd3, 5'd7, res, rdo, lat);
        checks++;
        if (res !== 32'd333 || rdo !== 5'd7 || lat != NORM_LAT) begin
            errors++; $display("FAIL after_reset_op: got %0d/%0d lat %0d want 333/7 lat %0d",
                               res, rdo, lat, NORM_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int          ndone, lat, consec;
        logic        prev_done;
        logic [31:0] res;
        logic [4:0]  rdo;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        func3 = 3'd5; opA = 32'd100; opB = 32'd7; rdIn = 5'd3; start = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b want 1", busy); end
        @(posedge clk);
        #1 func3 = 3'd0; opA = 32'd9; opB = 32'd9; rdIn = 5'd4;
        ndone = 0; lat = -1; consec = 0; prev_done = 1'b0; res = '0; rdo = '0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 10) start = 1'b0;
            if (done && prev_done) consec++;
            if (done) begin
                ndone++; lat = n; res = result; rdo = rdOut;
            end
            prev_done = done;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL b2b_count: got %0d want 1", ndone); end
        checks++;
        if (res !== 32'd14 || rdo !== 5'd3 || lat != NORM_LAT) begin
            errors++; $display("FAIL b2b_result: got %0d/%0d lat %0d want 14/3 lat %0d",
                               res, rdo, lat, NORM_LAT);
        end
        checks++; if (consec != 0) begin errors++; $display("FAIL b2b_consec_done: got %0d want 0", consec); end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                      32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        logic [4:0]  rd, rdo;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            exp  = ref_model(f, a, b);
            elat = ref_lat(f, a, b);
            run_op(f, a, b, rd, res, rdo, lat);
            checks++;
            if (res !== exp || rdo !== rd || lat != elat) begin
                errors++;
                $display("FAIL rand%0d f=%0d a=%h b=%h: got %h/%0d lat %0d want %h/%0d lat %0d",
                         i, f, a, b, res, rdo, lat, exp, rd, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
